// File: rtl/apu_dispatcher.sv
// Core-side APU offload initiator: buffers offloaded vector instructions in a small FIFO,
// issues them one at a time over the req/gnt handshake and returns scalar results to the register file.
module apu_dispatcher #(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              offload_valid,
    output logic              offload_ready,
    input  logic [31:0]       offload_instr,
    input  logic [31:0]       offload_op_a,
    input  logic [31:0]       offload_op_b,
    input  logic [4:0]        offload_rd,
    input  logic              offload_wb,
    output logic              apu_req,
    input  logic              apu_gnt,
    output logic [2:0][31:0]  apu_operands,
    output logic [5:0]        apu_op,
    output logic [14:0]       apu_flags_o,
    input  logic              apu_rvalid,
    input  logic [31:0]       apu_result,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              busy,
    output logic              timeout_err,
    output logic              spurious_rsp
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [31:0]   r_instrMem [FIFO_DEPTH];
    logic [31:0]   r_opAMem   [FIFO_DEPTH];
    logic [31:0]   r_opBMem   [FIFO_DEPTH];
    logic [4:0]    r_rdMem    [FIFO_DEPTH];
    logic          r_wbMem    [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic [TW-1:0] r_timer;
    logic [4:0]    r_respRd;
    logic          r_respWb;
    logic          r_wbValid;
    logic [4:0]    r_wbRd;
    logic [31:0]   r_wbData;
    logic          r_timeoutErr;
    logic          r_spurious;

    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;
    logic w_inResp;
    logic w_timerExpired;

    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == CW'(FIFO_DEPTH));
    assign w_push         = offload_valid && !w_full;
    assign w_pop          = (r_state == S_REQ) && apu_gnt;
    assign w_inResp       = (r_state == S_RESP);
    assign w_timerExpired = (r_timer == TW'(TIMEOUT_CYCLES - 1));

    assign offload_ready = !w_full;
    assign apu_flags_o   = '0;
    assign wb_valid      = r_wbValid;
    assign wb_rd         = r_wbRd;
    assign wb_data       = r_wbData;
    assign busy          = !w_empty || (r_state != S_IDLE);
    assign timeout_err   = r_timeoutErr;
    assign spurious_rsp  = r_spurious;

    // Payload storage has no reset; validity is tracked purely by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= offload_instr;
            r_opAMem[r_wrPtr]   <= offload_op_a;
            r_opBMem[r_wrPtr]   <= offload_op_b;
            r_rdMem[r_wrPtr]    <= offload_rd;
            r_wbMem[r_wrPtr]    <= offload_wb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Operands are only visible on the bus while a request is pending.
    always_comb begin
        w_nextState  = r_state;
        apu_req      = 1'b0;
        apu_operands = '0;
        apu_op       = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_nextState = S_REQ;
                end
            end
            S_REQ: begin
                apu_req         = 1'b1;
                apu_operands[0] = r_opAMem[r_rdPtr];
                apu_operands[1] = r_opBMem[r_rdPtr];
                apu_operands[2] = r_instrMem[r_rdPtr];
                apu_op          = r_instrMem[r_rdPtr][31:26];
                if (apu_gnt) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (apu_rvalid || w_timerExpired) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer  <= '0;
            r_respRd <= '0;
            r_respWb <= 1'b0;
        end else if (w_pop) begin
            r_timer  <= '0;
            r_respRd <= r_rdMem[r_rdPtr];
            r_respWb <= r_wbMem[r_rdPtr];
        end else if (w_inResp && !w_timerExpired) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // A response in the same cycle as the timer expiring still counts as a valid completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wbValid    <= 1'b0;
            r_wbRd       <= '0;
            r_wbData     <= '0;
            r_timeoutErr <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            r_wbValid <= w_inResp && apu_rvalid && r_respWb;
            if (w_inResp && apu_rvalid && r_respWb) begin
                r_wbRd   <= r_respRd;
                r_wbData <= apu_result;
            end
            if (w_inResp && !apu_rvalid && w_timerExpired) begin
                r_timeoutErr <= 1'b1;
            end
            if (apu_rvalid && !w_inResp) begin
                r_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apu_dispatcher.sv
// Scoreboard bench for apu_dispatcher: issue and writeback expectations are queued as stimulus is driven
// and retired by a negedge monitor when the DUT grants or writes back.
module tb_apu_dispatcher;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] opB;
        logic [31:0] opA;
    } issue_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             offload_valid;
    logic             offload_ready;
    logic [31:0]      offload_instr;
    logic [31:0]      offload_op_a;
    logic [31:0]      offload_op_b;
    logic [4:0]       offload_rd;
    logic             offload_wb;
    logic             apu_req;
    logic             apu_gnt;
    logic [2:0][31:0] apu_operands;
    logic [5:0]       apu_op;
    logic [14:0]      apu_flags_o;
    logic             apu_rvalid;
    logic [31:0]      apu_result;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             busy;
    logic             timeout_err;
    logic             spurious_rsp;

    int nAssert = 0;
    int nFail   = 0;
    int wbSeen  = 0;

    issue_t      issueQ[$];
    logic [36:0] wbQ[$];

    apu_dispatcher #(.FIFO_DEPTH(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk),
        .reset(reset),
        .offload_valid(offload_valid),
        .offload_ready(offload_ready),
        .offload_instr(offload_instr),
        .offload_op_a(offload_op_a),
        .offload_op_b(offload_op_b),
        .offload_rd(offload_rd),
        .offload_wb(offload_wb),
        .apu_req(apu_req),
        .apu_gnt(apu_gnt),
        .apu_operands(apu_operands),
        .apu_op(apu_op),
        .apu_flags_o(apu_flags_o),
        .apu_rvalid(apu_rvalid),
        .apu_result(apu_result),
        .wb_valid(wb_valid),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .busy(busy),
        .timeout_err(timeout_err),
        .spurious_rsp(spurious_rsp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAssert++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offload one instruction once the FIFO has room and record the expected issue.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic wb);
        int n = 0;
        while (!offload_ready && n < 50) begin
            tick();
            n++;
        end
        if (!offload_ready) begin
            checkOutput("push_ready_timeout", 0, 1);
            return;
        end
        offload_valid = 1'b1;
        offload_instr = instr;
        offload_op_a  = a;
        offload_op_b  = b;
        offload_rd    = rd;
        offload_wb    = wb;
        issueQ.push_back('{instr: instr, opB: b, opA: a});
        tick();
        offload_valid = 1'b0;
    endtask

    task automatic waitReq();
        int n = 0;
        while (!apu_req && n < 50) begin
            tick();
            n++;
        end
        if (!apu_req) checkOutput("req_timeout", 0, 1);
    endtask

    task automatic grantReq();
        waitReq();
        if (!apu_req) return;
        apu_gnt = 1'b1;
        tick();
        apu_gnt = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [31:0] result, input logic [4:0] rd, input logic expectWb);
        repeat (delay) tick();
        apu_rvalid = 1'b1;
        apu_result = result;
        if (expectWb) wbQ.push_back({rd, result});
        tick();
        apu_rvalid = 1'b0;
        apu_result = '0;
    endtask

    // Retire scoreboard entries at the falling edge, well away from the active edge.
    always @(negedge clk) begin
        issue_t      expIssue;
        logic [36:0] expWb;
        if (!reset) begin
            if (apu_req && apu_gnt) begin
                if (issueQ.size() == 0) begin
                    checkOutput("issue_unexpected", 1, 0);
                end else begin
                    expIssue = issueQ.pop_front();
                    checkOutput("issue_operands", apu_operands, expIssue);
                    checkOutput("issue_op", apu_op, expIssue.instr[31:26]);
                end
            end
            if (wb_valid) begin
                wbSeen++;
                if (wbQ.size() == 0) begin
                    checkOutput("wb_unexpected", 1, 0);
                end else begin
                    expWb = wbQ.pop_front();
                    checkOutput("wb_rd", wb_rd, expWb[36:32]);
                    checkOutput("wb_data", wb_data, expWb[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] fullInstr [3];
        logic [2:0][31:0] stallOps;
        int wbBefore;

        reset         = 1'b1;
        offload_valid = 1'b0;
        offload_instr = '0;
        offload_op_a  = '0;
        offload_op_b  = '0;
        offload_rd    = '0;
        offload_wb    = 1'b0;
        apu_gnt       = 1'b0;
        apu_rvalid    = 1'b0;
        apu_result    = '0;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_ready", offload_ready, 1);
        checkOutput("rst_req", apu_req, 0);
        checkOutput("rst_operands", apu_operands, 0);
        checkOutput("rst_op", apu_op, 0);
        checkOutput("rst_flags", apu_flags_o, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        checkOutput("rst_spurious", spurious_rsp, 0);
        reset = 1'b0;
        tick();

        // Single vsetvli with scalar writeback
        applyStimulus(32'h0D20_7057, 32'd7, 32'd0, 5'd5, 1'b1);
        grantReq();
        checkOutput("t1_req_low_after_gnt", apu_req, 0);
        respond(2, 32'd7, 5'd5, 1'b1);
        checkOutput("t1_wb_valid", wb_valid, 1);
        checkOutput("t1_wb_rd", wb_rd, 5);
        checkOutput("t1_wb_data", wb_data, 7);
        tick();
        checkOutput("t1_wb_pulse_end", wb_valid, 0);
        checkOutput("t1_busy_low", busy, 0);

        // Grant stall: request and operands hold for four cycles
        applyStimulus(32'h0221_80D7, 32'h1111_2222, 32'h3333_4444, 5'd3, 1'b0);
        waitReq();
        stallOps = {32'h0221_80D7, 32'h3333_4444, 32'h1111_2222};
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_req_stable", apu_req, 1);
            checkOutput("t2_ops_stable", apu_operands, stallOps);
            tick();
        end
        grantReq();
        respond(1, 32'h0, 5'd3, 1'b0);
        tick();
        checkOutput("t2_busy_low_single_pop", busy, 0);

        // FIFO full: third back-to-back push is refused
        fullInstr[0] = 32'h0000_1057;
        fullInstr[1] = 32'h0400_2057;
        fullInstr[2] = 32'h0800_3057;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t3_ready_push%0d", i), offload_ready, (i < 2) ? 1 : 0);
            if (offload_ready) issueQ.push_back('{instr: fullInstr[i], opB: 32'(i), opA: 32'(i + 100)});
            offload_valid = 1'b1;
            offload_instr = fullInstr[i];
            offload_op_a  = 32'(i + 100);
            offload_op_b  = 32'(i);
            offload_rd    = 5'(i);
            offload_wb    = 1'b0;
            tick();
        end
        offload_valid = 1'b0;
        checkOutput("t3_ready_low_full", offload_ready, 0);
        checkOutput("t3_req_pending", apu_req, 1);
        apu_gnt = 1'b1;
        tick();
        apu_gnt = 1'b0;
        checkOutput("t3_ready_after_gnt", offload_ready, 1);
        respond(2, 32'h0, 5'd0, 1'b0);
        grantReq();
        respond(1, 32'h0, 5'd1, 1'b0);
        tick();
        checkOutput("t3_busy_low", busy, 0);

        // In-order issue, only the wb=1 instruction writes back, issue spacing after rvalid
        wbBefore = wbSeen;
        applyStimulus(32'h0220_8057, 32'd1, 32'd2, 5'd4, 1'b0);
        applyStimulus(32'h4200_2557, 32'd0, 32'd0, 5'd10, 1'b1);
        grantReq();
        respond(1, 32'h1234_5678, 5'd4, 1'b0);
        checkOutput("t4_idle_after_rvalid", apu_req, 0);
        tick();
        checkOutput("t4_req_rvalid_plus2", apu_req, 1);
        grantReq();
        respond(1, 32'hDEAD_BEEF, 5'd10, 1'b1);
        tick();
        checkOutput("t4_single_wb", wbSeen - wbBefore, 1);

        // Response timeout, then a late response flagged spurious
        wbBefore = wbSeen;
        applyStimulus(32'h4200_2657, 32'd0, 32'd0, 5'd12, 1'b1);
        grantReq();
        repeat (63) tick();
        checkOutput("t5_no_timeout_yet", timeout_err, 0);
        checkOutput("t5_busy_in_resp", busy, 1);
        tick();
        checkOutput("t5_timeout_err", timeout_err, 1);
        checkOutput("t5_idle_busy_low", busy, 0);
        repeat (5) tick();
        checkOutput("t5_spurious_before", spurious_rsp, 0);
        apu_rvalid = 1'b1;
        apu_result = 32'hCAFE_0000;
        tick();
        apu_rvalid = 1'b0;
        checkOutput("t5_spurious_set", spurious_rsp, 1);
        tick();
        checkOutput("t5_no_wb", wbSeen - wbBefore, 0);

        // Reset while a response is outstanding and another entry waits in the FIFO
        applyStimulus(32'h0D20_7057, 32'd9, 32'd0, 5'd6, 1'b1);
        applyStimulus(32'h0D20_7057, 32'd8, 32'd0, 5'd7, 1'b1);
        grantReq();
        tick();
        reset = 1'b1;
        #1;
        checkOutput("t6_req_low", apu_req, 0);
        checkOutput("t6_busy_low", busy, 0);
        checkOutput("t6_ready_high", offload_ready, 1);
        checkOutput("t6_timeout_clr", timeout_err, 0);
        checkOutput("t6_spurious_clr", spurious_rsp, 0);
        checkOutput("t6_wb_valid_low", wb_valid, 0);
        checkOutput("t6_operands_zero", apu_operands, 0);
        issueQ.delete();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("t6_fifo_empty", busy, 0);
        checkOutput("t6_no_req", apu_req, 0);
        apu_rvalid = 1'b1;
        apu_result = 32'd9;
        tick();
        apu_rvalid = 1'b0;
        checkOutput("t6_spurious_set", spurious_rsp, 1);
        checkOutput("t6_no_wb", wb_valid, 0);
        tick();

        checkOutput("issue_queue_drained", issueQ.size(), 0);
        checkOutput("wb_queue_drained", wbQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
